// File: rtl/dispatch_stage_pkg.sv
// Shared widths, IQ entry packing and dispatch FSM encoding used by the dispatch
// stage and by the issue queue that consumes its write port.
package dispatch_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 6;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned FU_W   = 2;

    // Field order matches the IQ's 131-bit entry, MSB first.
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [PREG_W-1:0] dest;
        logic [PREG_W-1:0] rs1;
        logic [DATA_W-1:0] rs1_val;
        logic              rs1_ready;
        logic [PREG_W-1:0] rs2;
        logic [DATA_W-1:0] rs2_val;
        logic              rs2_ready;
        logic [DATA_W-1:0] imm;
        logic [FU_W-1:0]   fu;
        logic [ROB_W-1:0]  rob;
    } iq_entry_t;

    localparam int unsigned IQ_ENTRY_BITS = $bits(iq_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2
    } dispatch_state_e;

endpackage

// File: rtl/dispatch_stage_capture.sv
// Per-operand PRF value register plus CDB tag compare; the first matching
// broadcast after the operand is latched wins, preg 0 never matches.
module cdb_operand_capture
    import dispatch_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned PREG_BITS  = PREG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_snoop,
    input  logic [PREG_BITS-1:0]  i_tag,
    input  logic [DATA_WIDTH-1:0] i_prf_data,
    input  logic                  i_cdb_valid,
    input  logic [PREG_BITS-1:0]  i_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_cdb_value,
    output logic [DATA_WIDTH-1:0] o_val,
    output logic [DATA_WIDTH-1:0] o_fwd,
    output logic                  o_hit
);

    logic                  w_tag_live;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] r_val;
    logic [DATA_WIDTH-1:0] r_fwd;
    logic                  r_hit;

    assign w_tag_live = (i_tag != '0);
    assign w_match    = i_cdb_valid && w_tag_live && (i_cdb_tag == i_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_val <= '0;
            r_fwd <= '0;
            r_hit <= 1'b0;
        end else if (i_clear) begin
            r_hit <= 1'b0;
        end else begin
            if (i_load)
                r_val <= w_tag_live ? i_prf_data : '0;
            if ((i_load || i_snoop) && w_match && !r_hit) begin
                r_hit <= 1'b1;
                r_fwd <= i_cdb_value;
            end
        end
    end

    assign o_val = r_val;
    assign o_fwd = r_fwd;
    assign o_hit = r_hit;

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: accepts a renamed instruction, reads its operands from the PRF,
// merges CDB broadcasts and holds the entry on the IQ write port until a slot frees.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned PREG_BITS   = PREG_W,
    parameter int unsigned ROB_BITS    = ROB_W,
    parameter int unsigned OPCODE_BITS = OPC_W,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPCODE_BITS-1:0] in_opcode,
    input  logic [PREG_BITS-1:0]   in_phys_dest,
    input  logic [PREG_BITS-1:0]   in_phys_rs1,
    input  logic [PREG_BITS-1:0]   in_phys_rs2,
    input  logic [DATA_WIDTH-1:0]  in_immediate,
    input  logic [ROB_BITS-1:0]    in_rob_index,
    output logic [PREG_BITS-1:0]   prf_rs1_addr,
    output logic [PREG_BITS-1:0]   prf_rs2_addr,
    input  logic [DATA_WIDTH-1:0]  prf_rs1_data,
    input  logic [DATA_WIDTH-1:0]  prf_rs2_data,
    input  logic                   cdb_valid,
    input  logic [PREG_BITS-1:0]   cdb_tag,
    input  logic [DATA_WIDTH-1:0]  cdb_value,
    input  logic                   iq_free,
    output logic                   iq_write_enable,
    output logic [OPCODE_BITS-1:0] iq_opcode,
    output logic [PREG_BITS-1:0]   iq_phys_dest,
    output logic [PREG_BITS-1:0]   iq_phys_rs1,
    output logic [PREG_BITS-1:0]   iq_phys_rs2,
    output logic [DATA_WIDTH-1:0]  iq_immediate,
    output logic [ROB_BITS-1:0]    iq_rob_index,
    output logic [DATA_WIDTH-1:0]  iq_phys_rs1_val,
    output logic [DATA_WIDTH-1:0]  iq_phys_rs2_val,
    output logic [DATA_WIDTH-1:0]  iq_fwd_rs1,
    output logic [DATA_WIDTH-1:0]  iq_fwd_rs2,
    output logic                   iq_fwd_rs1_hit,
    output logic                   iq_fwd_rs2_hit,
    output logic [CNT_WIDTH-1:0]   dispatched_count,
    output logic [CNT_WIDTH-1:0]   stall_count
);

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [PREG_BITS-1:0]   dest;
        logic [PREG_BITS-1:0]   rs1;
        logic [PREG_BITS-1:0]   rs2;
        logic [DATA_WIDTH-1:0]  imm;
        logic [ROB_BITS-1:0]    rob;
        logic [DATA_WIDTH-1:0]  rs1_val;
        logic [DATA_WIDTH-1:0]  rs2_val;
        logic [DATA_WIDTH-1:0]  fwd1;
        logic [DATA_WIDTH-1:0]  fwd2;
        logic                   hit1;
        logic                   hit2;
    } view_t;

    dispatch_state_e r_state;
    dispatch_state_e w_next;

    logic [OPCODE_BITS-1:0] r_opcode;
    logic [PREG_BITS-1:0]   r_dest;
    logic [PREG_BITS-1:0]   r_rs1;
    logic [PREG_BITS-1:0]   r_rs2;
    logic [DATA_WIDTH-1:0]  r_imm;
    logic [ROB_BITS-1:0]    r_rob;
    logic [CNT_WIDTH-1:0]   r_dispatched;
    logic [CNT_WIDTH-1:0]   r_stall;

    logic [DATA_WIDTH-1:0]  w_rs1_val;
    logic [DATA_WIDTH-1:0]  w_rs2_val;
    logic [DATA_WIDTH-1:0]  w_fwd1;
    logic [DATA_WIDTH-1:0]  w_fwd2;
    logic                   w_hit1;
    logic                   w_hit2;

    logic  w_in_send;
    logic  w_in_read;
    logic  w_transfer;
    logic  w_accept;
    logic  w_clear;
    view_t w_view;
    view_t w_out;
    view_t r_hold;

    assign w_in_send  = (r_state == ST_SEND);
    assign w_in_read  = (r_state == ST_READ);
    assign w_transfer = w_in_send && iq_free && !flush && !reset;
    assign in_ready   = !reset && !flush && ((r_state == ST_IDLE) || (w_in_send && iq_free));
    assign w_accept   = in_ready && in_valid;
    assign w_clear    = flush || w_accept;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_READ;
            ST_READ: w_next = ST_SEND;
            ST_SEND: if (iq_free) w_next = in_valid ? ST_READ : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= '0;
            r_dest   <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_rob    <= '0;
        end else if (w_accept) begin
            r_opcode <= in_opcode;
            r_dest   <= in_phys_dest;
            r_rs1    <= in_phys_rs1;
            r_rs2    <= in_phys_rs2;
            r_imm    <= in_immediate;
            r_rob    <= in_rob_index;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dispatched <= '0;
            r_stall      <= '0;
        end else begin
            if (w_transfer)
                r_dispatched <= r_dispatched + CNT_WIDTH'(1);
            if (w_in_send && !iq_free && !flush)
                r_stall <= r_stall + CNT_WIDTH'(1);
        end
    end

    assign prf_rs1_addr = r_rs1;
    assign prf_rs2_addr = r_rs2;

    cdb_operand_capture #(
        .DATA_WIDTH (DATA_WIDTH),
        .PREG_BITS  (PREG_BITS)
    ) u_cap_rs1 (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load      (w_in_read),
        .i_snoop     (w_in_send),
        .i_tag       (r_rs1),
        .i_prf_data  (prf_rs1_data),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .i_cdb_value (cdb_value),
        .o_val       (w_rs1_val),
        .o_fwd       (w_fwd1),
        .o_hit       (w_hit1)
    );

    cdb_operand_capture #(
        .DATA_WIDTH (DATA_WIDTH),
        .PREG_BITS  (PREG_BITS)
    ) u_cap_rs2 (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load      (w_in_read),
        .i_snoop     (w_in_send),
        .i_tag       (r_rs2),
        .i_prf_data  (prf_rs2_data),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .i_cdb_value (cdb_value),
        .o_val       (w_rs2_val),
        .o_fwd       (w_fwd2),
        .o_hit       (w_hit2)
    );

    always_comb begin
        w_view = '{opcode: r_opcode, dest: r_dest, rs1: r_rs1, rs2: r_rs2,
                   imm: r_imm, rob: r_rob, rs1_val: w_rs1_val, rs2_val: w_rs2_val,
                   fwd1: w_fwd1, fwd2: w_fwd2, hit1: w_hit1, hit2: w_hit2};
    end

    // Entry registers are reused by the next accept, so the port shows a
    // snapshot of the last SEND-cycle entry whenever the FSM is not in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_in_send) begin
            r_hold <= w_view;
            if (flush) begin
                r_hold.hit1 <= 1'b0;
                r_hold.hit2 <= 1'b0;
            end
        end
    end

    assign w_out = w_in_send ? w_view : r_hold;

    assign iq_write_enable  = w_transfer;
    assign iq_opcode        = w_out.opcode;
    assign iq_phys_dest     = w_out.dest;
    assign iq_phys_rs1      = w_out.rs1;
    assign iq_phys_rs2      = w_out.rs2;
    assign iq_immediate     = w_out.imm;
    assign iq_rob_index     = w_out.rob;
    assign iq_phys_rs1_val  = w_out.rs1_val;
    assign iq_phys_rs2_val  = w_out.rs2_val;
    assign iq_fwd_rs1       = w_out.fwd1;
    assign iq_fwd_rs2       = w_out.fwd2;
    assign iq_fwd_rs1_hit   = w_out.hit1;
    assign iq_fwd_rs2_hit   = w_out.hit2;
    assign dispatched_count = r_dispatched;
    assign stall_count      = r_stall;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: an instruction-level model predicts every
// cycle's outputs, plus literal checks on hand-computed values.
module tb_dispatch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [5:0]  in_phys_dest, in_phys_rs1, in_phys_rs2, in_rob_index;
    logic [31:0] in_immediate;
    logic [5:0]  prf_rs1_addr, prf_rs2_addr;
    logic [31:0] prf_rs1_data, prf_rs2_data;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iq_free, iq_write_enable;
    logic [6:0]  iq_opcode;
    logic [5:0]  iq_phys_dest, iq_phys_rs1, iq_phys_rs2, iq_rob_index;
    logic [31:0] iq_immediate, iq_phys_rs1_val, iq_phys_rs2_val, iq_fwd_rs1, iq_fwd_rs2;
    logic        iq_fwd_rs1_hit, iq_fwd_rs2_hit;
    logic [31:0] dispatched_count, stall_count;

    logic [31:0] prf_mem [64];
    assign prf_rs1_data = prf_mem[prf_rs1_addr];
    assign prf_rs2_data = prf_mem[prf_rs2_addr];

    dispatch_stage #(
        .DATA_WIDTH(32), .PREG_BITS(6), .ROB_BITS(6), .OPCODE_BITS(7), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_phys_dest(in_phys_dest), .in_phys_rs1(in_phys_rs1),
        .in_phys_rs2(in_phys_rs2), .in_immediate(in_immediate), .in_rob_index(in_rob_index),
        .prf_rs1_addr(prf_rs1_addr), .prf_rs2_addr(prf_rs2_addr),
        .prf_rs1_data(prf_rs1_data), .prf_rs2_data(prf_rs2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iq_free(iq_free), .iq_write_enable(iq_write_enable),
        .iq_opcode(iq_opcode), .iq_phys_dest(iq_phys_dest), .iq_phys_rs1(iq_phys_rs1),
        .iq_phys_rs2(iq_phys_rs2), .iq_immediate(iq_immediate), .iq_rob_index(iq_rob_index),
        .iq_phys_rs1_val(iq_phys_rs1_val), .iq_phys_rs2_val(iq_phys_rs2_val),
        .iq_fwd_rs1(iq_fwd_rs1), .iq_fwd_rs2(iq_fwd_rs2),
        .iq_fwd_rs1_hit(iq_fwd_rs1_hit), .iq_fwd_rs2_hit(iq_fwd_rs2_hit),
        .dispatched_count(dispatched_count), .stall_count(stall_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: an entry becomes sendable one cycle after it is
    // accepted, and captures the first nonzero-tag CDB match while it is held.
    bit          m_have = 1'b0;
    int          m_age  = 0;
    logic [6:0]  m_opc  = '0;
    logic [5:0]  m_dest = '0, m_rs1 = '0, m_rs2 = '0, m_rob = '0;
    logic [31:0] m_imm  = '0, m_val1 = '0, m_val2 = '0, m_fwd1 = '0, m_fwd2 = '0;
    bit          m_hit1 = 1'b0, m_hit2 = 1'b0;
    logic [31:0] m_disp = '0, m_stall = '0;

    always @(posedge clk) begin : model
        bit b_wr, b_rdy;
        if (reset) begin
            m_have  = 1'b0;
            m_disp  = '0;
            m_stall = '0;
        end else if (flush) begin
            m_have = 1'b0;
        end else begin
            b_wr  = m_have && (m_age >= 1) && iq_free;
            b_rdy = !m_have || b_wr;
            if (m_have && cdb_valid && cdb_tag != 6'd0) begin
                if (cdb_tag == m_rs1 && !m_hit1) begin m_hit1 = 1'b1; m_fwd1 = cdb_value; end
                if (cdb_tag == m_rs2 && !m_hit2) begin m_hit2 = 1'b1; m_fwd2 = cdb_value; end
            end
            if (b_wr) begin
                m_disp = m_disp + 32'd1;
                m_have = 1'b0;
            end else if (m_have && m_age >= 1) begin
                m_stall = m_stall + 32'd1;
            end
            if (m_have) m_age++;
            if (b_rdy && in_valid) begin
                m_have = 1'b1;  m_age  = 0;
                m_opc  = in_opcode;    m_dest = in_phys_dest;
                m_rs1  = in_phys_rs1;  m_rs2  = in_phys_rs2;
                m_imm  = in_immediate; m_rob  = in_rob_index;
                m_val1 = (in_phys_rs1 == 6'd0) ? 32'd0 : prf_mem[in_phys_rs1];
                m_val2 = (in_phys_rs2 == 6'd0) ? 32'd0 : prf_mem[in_phys_rs2];
                m_hit1 = 1'b0;  m_hit2 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit e_wr, e_rdy;
        e_wr  = !reset && !flush && m_have && (m_age >= 1) && iq_free;
        e_rdy = !reset && !flush && (!m_have || ((m_age >= 1) && iq_free));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("iq_write_enable", 32'(iq_write_enable), 32'(e_wr));
        chk("dispatched_count", dispatched_count, m_disp);
        chk("stall_count", stall_count, m_stall);
        if (m_have && m_age == 0) begin
            chk("prf_rs1_addr", 32'(prf_rs1_addr), 32'(m_rs1));
            chk("prf_rs2_addr", 32'(prf_rs2_addr), 32'(m_rs2));
        end
        if (m_have && m_age >= 1) begin
            chk("iq_opcode", 32'(iq_opcode), 32'(m_opc));
            chk("iq_phys_dest", 32'(iq_phys_dest), 32'(m_dest));
            chk("iq_phys_rs1", 32'(iq_phys_rs1), 32'(m_rs1));
            chk("iq_phys_rs2", 32'(iq_phys_rs2), 32'(m_rs2));
            chk("iq_immediate", iq_immediate, m_imm);
            chk("iq_rob_index", 32'(iq_rob_index), 32'(m_rob));
            chk("iq_rs1_val", iq_phys_rs1_val, m_val1);
            chk("iq_rs2_val", iq_phys_rs2_val, m_val2);
            chk("iq_rs1_hit", 32'(iq_fwd_rs1_hit), 32'(m_hit1));
            chk("iq_rs2_hit", 32'(iq_fwd_rs2_hit), 32'(m_hit2));
            if (m_hit1) chk("iq_fwd_rs1", iq_fwd_rs1, m_fwd1);
            if (m_hit2) chk("iq_fwd_rs2", iq_fwd_rs2, m_fwd2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [5:0] d, input logic [5:0] r1,
                         input logic [5:0] r2, input logic [31:0] imm, input logic [5:0] rob);
        in_valid = 1'b1;  in_opcode = opc;  in_phys_dest = d;
        in_phys_rs1 = r1; in_phys_rs2 = r2; in_immediate = imm; in_rob_index = rob;
    endtask

    task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] val);
        cdb_valid = v; cdb_tag = t; cdb_value = val;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [6:0] wpat;
        logic [6:0] rpat;
        wpat = 7'b1010100;
        rpat = 7'b1010101;
        for (int i = 0; i < 64; i++) prf_mem[i] = 32'hA000_0000 + 32'(i);
        prf_mem[0] = 32'hFFFF_FFFF;
        prf_mem[5] = 32'h11;
        prf_mem[7] = 32'h22;
        reset = 1'b1; flush = 1'b0; iq_free = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_phys_dest = '0; in_phys_rs1 = '0;
        in_phys_rs2 = '0; in_immediate = '0; in_rob_index = '0;
        cdb(1'b0, 6'd0, 32'd0);

        // reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(iq_write_enable), 32'd0);
        chk("rst_disp", dispatched_count, 32'd0);
        tick; tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_iq_opcode", 32'(iq_opcode), 32'd0);
        chk("rst_iq_rs1_val", iq_phys_rs1_val, 32'd0);
        tick;

        // basic dispatch, write two cycles after accept
        drive(7'h33, 6'd9, 6'd5, 6'd7, 32'h123, 6'd3);
        tick; in_valid = 1'b0;
        tick;
        @(negedge clk);
        chk("t1_we", 32'(iq_write_enable), 32'd1);
        chk("t1_rs1_val", iq_phys_rs1_val, 32'h11);
        chk("t1_rs2_val", iq_phys_rs2_val, 32'h22);
        chk("t1_hits", {30'd0, iq_fwd_rs1_hit, iq_fwd_rs2_hit}, 32'd0);
        tick;
        @(negedge clk);
        chk("t1_disp", dispatched_count, 32'd1);
        tick;

        // same-cycle bypass during READ
        drive(7'h13, 6'd10, 6'd5, 6'd7, 32'h0, 6'd4);
        tick; in_valid = 1'b0; cdb(1'b1, 6'd5, 32'hDEAD);
        tick; cdb(1'b0, 6'd0, 32'd0);
        @(negedge clk);
        chk("t2_fwd1", iq_fwd_rs1, 32'hDEAD);
        chk("t2_hit1", 32'(iq_fwd_rs1_hit), 32'd1);
        chk("t2_hit2", 32'(iq_fwd_rs2_hit), 32'd0);
        tick;

        // stall four cycles, capture while waiting, first capture wins
        iq_free = 1'b0;
        drive(7'h03, 6'd11, 6'd5, 6'd7, 32'h40, 6'd5);
        tick; in_valid = 1'b0;
        tick;
        tick;
        tick; cdb(1'b1, 6'd7, 32'hBEEF);
        tick; cdb(1'b1, 6'd7, 32'h1234);
        tick; cdb(1'b0, 6'd0, 32'd0); iq_free = 1'b1;
        @(negedge clk);
        chk("t3_we", 32'(iq_write_enable), 32'd1);
        chk("t3_stall", stall_count, 32'd4);
        chk("t3_fwd2", iq_fwd_rs2, 32'hBEEF);
        chk("t3_hit2", 32'(iq_fwd_rs2_hit), 32'd1);
        chk("t3_opcode", 32'(iq_opcode), 32'h03);
        tick;
        @(negedge clk);
        chk("t3_disp", dispatched_count, 32'd3);
        tick;

        // preg 0 is hardwired zero and never hits
        drive(7'h33, 6'd12, 6'd0, 6'd0, 32'h7, 6'd6);
        tick; in_valid = 1'b0; cdb(1'b1, 6'd0, 32'h5555);
        tick;
        @(negedge clk);
        chk("t4_rs1_val", iq_phys_rs1_val, 32'd0);
        chk("t4_rs2_val", iq_phys_rs2_val, 32'd0);
        chk("t4_hits", {30'd0, iq_fwd_rs1_hit, iq_fwd_rs2_hit}, 32'd0);
        cdb(1'b0, 6'd0, 32'd0);
        tick;

        // three back-to-back instructions; second has rs1==rs2 with a CDB match
        drive(7'h20, 6'd20, 6'd1, 6'd2, 32'h100, 6'd7);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t5_we_pattern", 32'(iq_write_enable), 32'(wpat[i]));
            chk("t5_ready_pattern", 32'(in_ready), 32'(rpat[i]));
            if (i == 4) begin
                chk("t5_both_hit", {30'd0, iq_fwd_rs1_hit, iq_fwd_rs2_hit}, 32'd3);
                chk("t5_fwd_same", iq_fwd_rs1, 32'h99);
            end
            tick;
            in_opcode = 7'h21 + 7'(i); in_immediate = 32'h200 + 32'(i);
            if (i == 1) begin in_phys_rs1 = 6'd9; in_phys_rs2 = 6'd9; end
            if (i == 2) cdb(1'b1, 6'd9, 32'h99);
            if (i == 3) begin cdb(1'b0, 6'd0, 32'd0); in_phys_rs1 = 6'd3; in_phys_rs2 = 6'd4; end
            if (i >= 4) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("t5_disp", dispatched_count, 32'd7);
        tick;

        // flush in SEND with a free IQ slot
        drive(7'h01, 6'd13, 6'd2, 6'd3, 32'h1, 6'd8);
        tick; in_valid = 1'b0;
        tick; flush = 1'b1;
        @(negedge clk);
        chk("t6_flush_we", 32'(iq_write_enable), 32'd0);
        chk("t6_flush_ready", 32'(in_ready), 32'd0);
        tick; flush = 1'b0;
        @(negedge clk);
        chk("t6_after_ready", 32'(in_ready), 32'd1);
        chk("t6_after_disp", dispatched_count, 32'd7);
        tick;

        // reset while stalled in SEND
        drive(7'h02, 6'd14, 6'd5, 6'd6, 32'h2, 6'd9);
        tick; in_valid = 1'b0; iq_free = 1'b0;
        tick;
        tick; reset = 1'b1;
        @(negedge clk);
        chk("t7_rst_ready", 32'(in_ready), 32'd0);
        chk("t7_rst_we", 32'(iq_write_enable), 32'd0);
        tick; reset = 1'b0;
        @(negedge clk);
        chk("t7_disp", dispatched_count, 32'd0);
        chk("t7_stall", stall_count, 32'd0);
        chk("t7_iq_opcode", 32'(iq_opcode), 32'd0);
        chk("t7_iq_imm", iq_immediate, 32'd0);
        chk("t7_ready", 32'(in_ready), 32'd1);
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
